// File: rtl/ibuf_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ibuf_pkg : shared state encoding, bank/credit constants and bank rotation
//            for the input-buffer write path.                    Rev 1.0
// ---------------------------------------------------------------------------
package ibuf_pkg;

    localparam int IBUF_BANKS    = 3;
    localparam int IBUF_CRED_MAX = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_STALL = 2'd2,
        ST_DONE  = 2'd3
    } ibuf_state_e;

    function automatic logic [1:0] bank_rotate(input logic [1:0] bank);
        return (bank == 2'd2) ? 2'd0 : bank + 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ibuf_credit_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ibuf_credit_cnt : 2-bit saturating row-credit counter (clear loads max).
//                                                                 Rev 1.0
// ---------------------------------------------------------------------------
module ibuf_credit_cnt
    import ibuf_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [1:0] cnt_o,
    output logic       zero_o
);

    localparam logic [1:0] CRED_MAX = 2'(IBUF_CRED_MAX);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    // A release and a consume in the same cycle cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = CRED_MAX;
        end else if (inc_i && !dec_i && (cnt_q != CRED_MAX)) begin
            cnt_d = cnt_q + 2'd1;
        end else if (dec_i && !inc_i && (cnt_q != 2'd0)) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CRED_MAX;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == 2'd0);

endmodule

`default_nettype wire

// File: rtl/ibuf_wr_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ibuf_wr_ctrl : write controller for the 3-bank rotating input line buffer.
//                Define IBUF_PAD_EN to wrap each frame in all-zero rows. Rev 1.0
// ---------------------------------------------------------------------------
module ibuf_wr_ctrl
    import ibuf_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 128,
    parameter int RW = 10
) (
    input  logic                  SYS_CLK,
    input  logic                  SYS_NRST,
    input  logic                  CFG_START,
    input  logic [AW-1:0]         CFG_ROW_LEN,
    input  logic [RW-1:0]         CFG_ROW_NUM,
    input  logic                  S_VALID,
    input  logic [DW-1:0]         S_DATA,
    output logic                  S_READY,
    input  logic                  RD_ROW_FREE,
    output logic [IBUF_BANKS-1:0] CEN,
    output logic [IBUF_BANKS-1:0] WEN,
    output logic [AW-1:0]         A0,
    output logic [AW-1:0]         A1,
    output logic [AW-1:0]         A2,
    output logic [DW-1:0]         DIN0,
    output logic [DW-1:0]         DIN1,
    output logic [DW-1:0]         DIN2,
    output logic                  ROW_DONE,
    output logic [1:0]            ROW_BANK,
    output logic [RW-1:0]         ROW_IDX,
    output logic                  FRAME_DONE,
    output logic                  BUSY
);

    // Row counter carries one extra bit so ROW_NUM+2 pad-mode frames cannot wrap.
    function automatic logic [RW:0] last_row(input logic [RW-1:0] num);
`ifdef IBUF_PAD_EN
        return {1'b0, num} + (RW+1)'(1);
`else
        return {1'b0, num} - (RW+1)'(1);
`endif
    endfunction

    ibuf_state_e           state_q, state_d;
    logic [AW-1:0]         len_q, len_d;
    logic [RW-1:0]         num_q, num_d;
    logic [AW-1:0]         col_q, col_d;
    logic [RW:0]           row_q, row_d;
    logic [1:0]            bank_q, bank_d;
    logic                  rdy_q, rdy_d;
    logic [IBUF_BANKS-1:0] strobe_q, strobe_d;
    logic [AW-1:0]         a0_q, a0_d, a1_q, a1_d, a2_q, a2_d;
    logic [DW-1:0]         din0_q, din0_d, din1_q, din1_d, din2_q, din2_d;
    logic                  row_done_q, row_done_d;
    logic [1:0]            row_bank_q, row_bank_d;
    logic [RW-1:0]         row_idx_q, row_idx_d;
    logic                  frame_done_q, frame_done_d;

    logic [1:0]            w_cred_cnt;
    logic                  w_cred_zero;
    logic                  w_start_ok;
    logic                  w_pad_cur;
    logic                  w_pad_nxt;
    logic                  w_wr;
    logic                  w_row_end;
    logic                  w_frame_end;
    logic                  w_inc;
    logic [DW-1:0]         w_wdata;

    assign w_start_ok  = (state_q == ST_IDLE) && CFG_START &&
                         (CFG_ROW_LEN != '0) && (CFG_ROW_NUM != '0);
    assign w_inc       = RD_ROW_FREE && (state_q != ST_IDLE);

`ifdef IBUF_PAD_EN
    assign w_pad_cur   = (row_q == '0) || (row_q == last_row(num_q));
    assign w_pad_nxt   = (row_d == '0) || (row_d == last_row(num_d));
`else
    assign w_pad_cur   = 1'b0;
    assign w_pad_nxt   = 1'b0;
`endif

    // Pad rows self-generate one word per cycle while the input is held off.
    assign w_wr        = (S_VALID && rdy_q) || ((state_q == ST_WRITE) && w_pad_cur);
    assign w_wdata     = w_pad_cur ? '0 : S_DATA;
    assign w_row_end   = w_wr && (col_q == (len_q - AW'(1)));
    assign w_frame_end = w_row_end && (row_q == last_row(num_q));

    ibuf_credit_cnt u_credit (
        .clk    (SYS_CLK),
        .rst_n  (SYS_NRST),
        .clr_i  (w_start_ok),
        .inc_i  (w_inc),
        .dec_i  (w_row_end),
        .cnt_o  (w_cred_cnt),
        .zero_o (w_cred_zero)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        num_d   = num_q;
        col_d   = col_q;
        row_d   = row_q;
        bank_d  = bank_q;
        case (state_q)
            ST_IDLE: begin
                if (w_start_ok) begin
                    state_d = ST_WRITE;
                    len_d   = CFG_ROW_LEN;
                    num_d   = CFG_ROW_NUM;
                    col_d   = '0;
                    row_d   = '0;
                    bank_d  = 2'd0;
                end
            end
            ST_WRITE: begin
                if (w_row_end) begin
                    col_d  = '0;
                    row_d  = row_q + (RW+1)'(1);
                    bank_d = bank_rotate(bank_q);
                    // Stall only when this consume empties the credits with no release alongside.
                    if (w_frame_end) begin
                        state_d = ST_DONE;
                    end else if ((w_cred_cnt == 2'd1) && !w_inc) begin
                        state_d = ST_STALL;
                    end
                end else if (w_wr) begin
                    col_d = col_q + AW'(1);
                end
            end
            ST_STALL: begin
                if (w_inc || !w_cred_zero) begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rdy_d = (state_d == ST_WRITE) && !w_pad_nxt;

    always_comb begin
        strobe_d     = '0;
        a0_d         = a0_q;
        a1_d         = a1_q;
        a2_d         = a2_q;
        din0_d       = din0_q;
        din1_d       = din1_q;
        din2_d       = din2_q;
        row_done_d   = w_row_end;
        row_bank_d   = row_bank_q;
        row_idx_d    = row_idx_q;
        frame_done_d = (state_q == ST_DONE);
        if (w_wr) begin
            case (bank_q)
                2'd0: begin
                    strobe_d = 3'b001;
                    a0_d     = col_q;
                    din0_d   = w_wdata;
                end
                2'd1: begin
                    strobe_d = 3'b010;
                    a1_d     = col_q;
                    din1_d   = w_wdata;
                end
                default: begin
                    strobe_d = 3'b100;
                    a2_d     = col_q;
                    din2_d   = w_wdata;
                end
            endcase
        end
        if (w_row_end) begin
            row_bank_d = bank_q;
            row_idx_d  = row_q[RW-1:0];
        end
    end

    always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            num_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            bank_q       <= 2'd0;
            rdy_q        <= 1'b0;
            strobe_q     <= '0;
            a0_q         <= '0;
            a1_q         <= '0;
            a2_q         <= '0;
            din0_q       <= '0;
            din1_q       <= '0;
            din2_q       <= '0;
            row_done_q   <= 1'b0;
            row_bank_q   <= 2'd0;
            row_idx_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            num_q        <= num_d;
            col_q        <= col_d;
            row_q        <= row_d;
            bank_q       <= bank_d;
            rdy_q        <= rdy_d;
            strobe_q     <= strobe_d;
            a0_q         <= a0_d;
            a1_q         <= a1_d;
            a2_q         <= a2_d;
            din0_q       <= din0_d;
            din1_q       <= din1_d;
            din2_q       <= din2_d;
            row_done_q   <= row_done_d;
            row_bank_q   <= row_bank_d;
            row_idx_q    <= row_idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign S_READY    = rdy_q;
    assign CEN        = strobe_q;
    assign WEN        = strobe_q;
    assign A0         = a0_q;
    assign A1         = a1_q;
    assign A2         = a2_q;
    assign DIN0       = din0_q;
    assign DIN1       = din1_q;
    assign DIN2       = din2_q;
    assign ROW_DONE   = row_done_q;
    assign ROW_BANK   = row_bank_q;
    assign ROW_IDX    = row_idx_q;
    assign FRAME_DONE = frame_done_q;
    assign BUSY       = (state_q != ST_IDLE);

endmodule

`default_nettype wire
